// File: rtl/img_tx_scheduler.sv
// img_tx_scheduler
//   Shares one UART transmitter between NUM_SRC image BRAMs. Pending image
//   requests are served round-robin; each frame is a sync byte, a source-index
//   byte, then every pixel of the source's BRAM in address order.
//
//   Optional: define IMG_TX_CHECKSUM_EN to append an 8-bit XOR of the frame's
//   pixel bytes after the last pixel.
//
// Ports
//   clk          system clock
//   rst_in       synchronous active-high reset
//   req_in       per-source image-ready request (pulse or level)
//   data_in      BRAM read data, source i on [8i+7:8i]
//   addr_out     shared BRAM read address
//   grant_out    one-hot selected source, zero when idle
//   tx_data_out  byte to uart_tx
//   tx_start_out one-cycle start strobe to uart_tx
//   tx_done_in   uart_tx idle flag
//   done_out     one-cycle pulse on bit i when source i's frame is finished
//   busy_out     high from grant until the last byte completes
//
// state     | meaning
// IDLE      | no frame active, arbitrating pending requests
// HDR0      | issue sync byte
// HDR1      | issue source-index byte
// FETCH     | wait for BRAM read latency, latch pixel
// SEND      | issue pixel byte
// CKSUM     | issue checksum byte (checksum build only)
// WAIT_ACC  | wait for uart_tx to accept the byte (drop of tx_done_in)
// WAIT_DONE | wait for uart_tx to finish the byte
// FINISH    | pulse done_out, release grant
module img_tx_scheduler #(
  parameter int          NUM_SRC    = 4,
  parameter int          IMG_PIXELS = 4096,
  parameter int          ADDR_W     = 14,
  parameter int          BRAM_LAT   = 2,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [NUM_SRC-1:0]     req_in,
  input  logic [8*NUM_SRC-1:0]   data_in,
  output logic [ADDR_W-1:0]      addr_out,
  output logic [NUM_SRC-1:0]     grant_out,
  output logic [7:0]             tx_data_out,
  output logic                   tx_start_out,
  input  logic                   tx_done_in,
  output logic [NUM_SRC-1:0]     done_out,
  output logic                   busy_out
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TMR_W = 8;
  // Cycles tx_done_in may stay high after a strobe before the byte is
  // considered lost (down-counter terminal value is reached on the 4th cycle).
  localparam logic [TMR_W-1:0] ACC_TMO = TMR_W'(3);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, FETCH, SEND, CKSUM, WAIT_ACC, WAIT_DONE, FINISH
  } state_t;

  state_t             state, state_nxt, ret;
  logic [IDX_W-1:0]   idx, rr_ptr, pick;
  logic               found;
  logic [NUM_SRC-1:0] pending;
  logic [TMR_W-1:0]   tmr;
  logic               issue, byte_done, last_pix;
  logic [7:0]         pix;
`ifdef IMG_TX_CHECKSUM_EN
  logic [7:0]         cksum;
`endif

  assign issue     = (state == HDR0) || (state == HDR1) || (state == SEND) || (state == CKSUM);
  assign byte_done = (state == WAIT_DONE) && tx_done_in;
  assign last_pix  = (addr_out == ADDR_W'(IMG_PIXELS - 1));
  assign pix       = data_in[int'(idx)*8 +: 8];

  // Round-robin search: first pending bit at or above rr_ptr, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && pending[(int'(rr_ptr) + k) % NUM_SRC]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state       <= IDLE;
      ret         <= IDLE;
      idx         <= '0;
      rr_ptr      <= '0;
      pending     <= '0;
      tmr         <= '0;
      addr_out    <= '0;
      tx_data_out <= '0;
`ifdef IMG_TX_CHECKSUM_EN
      cksum       <= '0;
`endif
    end else begin
      state <= state_nxt;
      // A request in the same cycle as the done pulse keeps the bit set.
      pending <= (pending & ~done_out) | req_in;

      case (state)
        IDLE: if (found) begin
          idx         <= pick;
          rr_ptr      <= (pick == IDX_W'(NUM_SRC - 1)) ? '0 : pick + 1'b1;
          addr_out    <= '0;
          tx_data_out <= SYNC_BYTE;
`ifdef IMG_TX_CHECKSUM_EN
          cksum       <= '0;
`endif
        end
        HDR0, HDR1, SEND, CKSUM: if (tx_done_in) begin
          ret <= state;
          tmr <= ACC_TMO;
        end
        WAIT_ACC: if (tx_done_in && tmr != '0) tmr <= tmr - 1'b1;
        WAIT_DONE: if (tx_done_in) begin
          case (ret)
            HDR0: tx_data_out <= {4'h0, 4'(idx)};
            HDR1: tmr <= TMR_W'(BRAM_LAT);
            SEND: if (!last_pix) begin
              addr_out <= addr_out + 1'b1;
              tmr      <= TMR_W'(BRAM_LAT);
            end else begin
`ifdef IMG_TX_CHECKSUM_EN
              tx_data_out <= cksum;
`endif
            end
            default: ;
          endcase
        end
        FETCH: if (tmr == '0) begin
          tx_data_out <= pix;
`ifdef IMG_TX_CHECKSUM_EN
          cksum       <= cksum ^ pix;
`endif
        end else begin
          tmr <= tmr - 1'b1;
        end
        FINISH: addr_out <= '0;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:                    if (found) state_nxt = HDR0;
      HDR0, HDR1, SEND, CKSUM: if (tx_done_in) state_nxt = WAIT_ACC;
      WAIT_ACC: begin
        if (!tx_done_in)     state_nxt = WAIT_DONE;
        else if (tmr == '0)  state_nxt = ret;  // lost byte: strobe it again
      end
      WAIT_DONE: if (tx_done_in) begin
        case (ret)
          HDR0: state_nxt = HDR1;
          HDR1: state_nxt = FETCH;
          SEND: begin
            if (!last_pix) state_nxt = FETCH;
`ifdef IMG_TX_CHECKSUM_EN
            else           state_nxt = CKSUM;
`else
            else           state_nxt = FINISH;
`endif
          end
          default: state_nxt = FINISH;
        endcase
      end
      FETCH:   if (tmr == '0) state_nxt = SEND;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    grant_out    = '0;
    done_out     = '0;
    busy_out     = 1'b0;
    tx_start_out = issue && tx_done_in;
    if (state != IDLE && state != FINISH) begin
      grant_out[idx] = 1'b1;
      busy_out       = 1'b1;
    end
    if (state == FINISH) done_out[idx] = 1'b1;
  end

endmodule
